mini_alu_seq: RTL and testbench

- Parametrised successor of the team's MiniAlu datapath/sequencer: fetches 28-bit instructions from an external combinational instruction ROM.
- Executes on an internal register file and drives the LED byte and a byte-wide output stream for the LCD controller.
- Adds over the previous generation:
  - configurable data/PC width and register depth;
  - hardware return-address stack for CALL/RET;
  - multicycle shift-add multiplier;
  - valid/ready output handshake;
  - HALT plus sticky fault reporting.

---
 rtl/mini_alu_seq_pkg.sv | 43 ++++
 rtl/mini_alu_seq_if.sv | 42 ++++
 rtl/mini_alu_seq_stack.sv | 53 +++++
 rtl/mini_alu_seq.sv | 218 +++++++++++++++++++++
 tb/tb_mini_alu_seq.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mini_alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mini_alu_defs (package)
// Purpose : Shared opcode values, sequencer state encoding and instruction
//           field positions for the mini_alu_seq core.
// Revision: 1.0 - initial release
// ============================================================================
package mini_alu_defs;

    // Opcodes carried in instruction bits [27:24]
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_STO  = 4'd3;
    localparam logic [3:0] OP_BLE  = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_LED  = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_CALL = 4'd8;
    localparam logic [3:0] OP_RET  = 4'd9;
    localparam logic [3:0] OP_OUT  = 4'd10;
    localparam logic [3:0] OP_HALT = 4'd11;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_EXEC = 2'd0,
        ST_MUL  = 2'd1,
        ST_OUT  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // Instruction field bit positions: op | dst | s1 | s0
    localparam int OP_HI  = 27;
    localparam int OP_LO  = 24;
    localparam int DST_HI = 23;
    localparam int DST_LO = 16;
    localparam int S1_HI  = 15;
    localparam int S1_LO  = 8;
    localparam int S0_HI  = 7;
    localparam int S0_LO  = 0;

endpackage
`default_nettype wire

// File: rtl/mini_alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : mini_alu_seq_if
// Purpose : Bundle of the core's instruction-fetch, LED, LCD byte stream
//           and status signals. master = core side, slave = environment.
// Revision: 1.0 - initial release
// ============================================================================
interface mini_alu_seq_if #(
    parameter int PC_W = 16
) ();
    logic [PC_W-1:0] oIAddr;
    logic [27:0]     iInstr;
    logic [7:0]      oLed;
    logic [7:0]      oOutData;
    logic            oOutValid;
    logic            iOutReady;
    logic            oHalt;
    logic            oStackFault;

    modport master (
        output oIAddr,
        input  iInstr,
        output oLed,
        output oOutData,
        output oOutValid,
        input  iOutReady,
        output oHalt,
        output oStackFault
    );

    modport slave (
        input  oIAddr,
        output iInstr,
        input  oLed,
        input  oOutData,
        input  oOutValid,
        output iOutReady,
        input  oHalt,
        input  oStackFault
    );
endinterface
`default_nettype wire

// File: rtl/mini_alu_seq_stack.sv
`default_nettype none
// ============================================================================
// Module  : return_stack_lifo
// Purpose : Return-address LIFO for CALL/RET. Pointer counts used entries;
//           the caller never pushes and pops in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
module return_stack_lifo #(
    parameter int PC_W        = 16,
    parameter int STACK_DEPTH = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            push,
    input  wire logic            pop,
    input  wire logic [PC_W-1:0] push_data,
    output logic                 full,
    output logic                 empty,
    output logic [PC_W-1:0]      top
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [SP_W-1:0]  sp;
    logic [PC_W-1:0]  mem [STACK_DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign wr_idx = IDX_W'(sp);
    assign rd_idx = IDX_W'(sp - SP_W'(1));
    assign full   = (sp == SP_W'(STACK_DEPTH));
    assign empty  = (sp == '0);
    assign top    = mem[rd_idx];

    // Entry count: up on push, down on pop, never past the limits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Storage holds no reset; only slots below the pointer are meaningful
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mini_alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : mini_alu_seq
// Purpose : Sequencer/datapath core. Fetches 28-bit instructions from an
//           external combinational ROM, executes on a local register file,
//           drives the LED byte and a valid/ready byte stream.
// Revision: 1.0 - initial release
// ============================================================================
module mini_alu_seq
    import mini_alu_defs::*;
#(
    parameter int DATA_W      = 16,
    parameter int PC_W        = 16,
    parameter int RF_DEPTH    = 256,
    parameter int STACK_DEPTH = 4
) (
    input  wire logic      Clock,
    input  wire logic      Reset,
    mini_alu_seq_if.master bus
);
    localparam int RA_W  = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [7:0]        led;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              halt;
    logic              stack_fault;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [DATA_W-1:0] mul_acc;
    logic [CNT_W-1:0]  mul_cnt;
    logic [RA_W-1:0]   mul_dst;

    logic [DATA_W-1:0] rf [RF_DEPTH];

    // Instruction decode
    logic [3:0]        op;
    logic [7:0]        f_dst, f_s1, f_s0;
    logic [RA_W-1:0]   a_dst, a_s1, a_s0;
    logic [DATA_W-1:0] rs1, rs0;
    logic [PC_W+7:0]   dst_ext;
    logic [PC_W-1:0]   target;
    logic [DATA_W+15:0] imm_ext;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   pc_inc;
    logic [DATA_W-1:0] mul_sum;

    assign op      = bus.iInstr[OP_HI:OP_LO];
    assign f_dst   = bus.iInstr[DST_HI:DST_LO];
    assign f_s1    = bus.iInstr[S1_HI:S1_LO];
    assign f_s0    = bus.iInstr[S0_HI:S0_LO];
    assign a_dst   = f_dst[RA_W-1:0];
    assign a_s1    = f_s1[RA_W-1:0];
    assign a_s0    = f_s0[RA_W-1:0];
    assign rs1     = rf[a_s1];
    assign rs0     = rf[a_s0];
    // Branch target and immediate are zero-extended, then cut to width
    assign dst_ext = {{PC_W{1'b0}}, f_dst};
    assign target  = dst_ext[PC_W-1:0];
    assign imm_ext = {{DATA_W{1'b0}}, f_s1, f_s0};
    assign imm     = imm_ext[DATA_W-1:0];
    assign pc_inc  = pc + PC_W'(1);
    // One shift-add step: accumulate the shifted multiplicand when the
    // current multiplier LSB is set
    assign mul_sum = mul_acc + (mul_b[0] ? mul_a : '0);

    // Return-address stack
    logic            stk_push, stk_pop, stk_full, stk_empty;
    logic [PC_W-1:0] stk_top;

    assign stk_push = !Reset && (state == ST_EXEC) && (op == OP_CALL) && !stk_full;
    assign stk_pop  = !Reset && (state == ST_EXEC) && (op == OP_RET)  && !stk_empty;

    return_stack_lifo #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (Clock),
        .rst       (Reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .full      (stk_full),
        .empty     (stk_empty),
        .top       (stk_top)
    );

    // Single register-file write port; suppressed while Reset is held so an
    // aborted multiply never lands
    logic              rf_we;
    logic [RA_W-1:0]   rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // Select the one write source for this cycle
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = a_dst;
        rf_wdata = '0;
        if (!Reset) begin
            if (state == ST_EXEC) begin
                case (op)
                    OP_ADD: begin rf_we = 1'b1; rf_wdata = rs1 + rs0; end
                    OP_SUB: begin rf_we = 1'b1; rf_wdata = rs1 - rs0; end
                    OP_STO: begin rf_we = 1'b1; rf_wdata = imm;       end
                    default: ;
                endcase
            end else if (state == ST_MUL && mul_cnt == LAST_ITER) begin
                rf_we    = 1'b1;
                rf_waddr = mul_dst;
                rf_wdata = mul_sum;
            end
        end
    end

    // Register file storage, deliberately not reset
    always_ff @(posedge Clock) begin
        if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    // Sequencer: one-cycle EXEC, multicycle MUL, OUT handshake, terminal HALT
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= ST_EXEC;
            pc          <= '0;
            led         <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            halt        <= 1'b0;
            stack_fault <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_acc     <= '0;
            mul_cnt     <= '0;
            mul_dst     <= '0;
        end else begin
            case (state)
                ST_EXEC: begin
                    case (op)
                        OP_BLE: pc <= (rs1 <= rs0) ? target : pc_inc;
                        OP_JMP: pc <= target;
                        OP_LED: begin
                            led <= rs1[7:0];
                            pc  <= pc_inc;
                        end
                        OP_MUL: begin
                            mul_a   <= rs1;
                            mul_b   <= rs0;
                            mul_acc <= '0;
                            mul_cnt <= '0;
                            mul_dst <= a_dst;
                            state   <= ST_MUL;
                        end
                        OP_CALL: begin
                            if (stk_full) begin
                                stack_fault <= 1'b1;
                                halt        <= 1'b1;
                                state       <= ST_HALT;
                            end else begin
                                pc <= target;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty) begin
                                stack_fault <= 1'b1;
                                halt        <= 1'b1;
                                state       <= ST_HALT;
                            end else begin
                                pc <= stk_top;
                            end
                        end
                        OP_OUT: begin
                            out_data  <= rs0[7:0];
                            out_valid <= 1'b1;
                            state     <= ST_OUT;
                        end
                        OP_HALT: begin
                            halt  <= 1'b1;
                            state <= ST_HALT;
                        end
                        default: pc <= pc_inc;
                    endcase
                end
                ST_MUL: begin
                    mul_acc <= mul_sum;
                    mul_a   <= mul_a << 1;
                    mul_b   <= mul_b >> 1;
                    mul_cnt <= mul_cnt + CNT_W'(1);
                    if (mul_cnt == LAST_ITER) begin
                        pc    <= pc_inc;
                        state <= ST_EXEC;
                    end
                end
                ST_OUT: begin
                    if (bus.iOutReady) begin
                        out_valid <= 1'b0;
                        pc        <= pc_inc;
                        state     <= ST_EXEC;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.oIAddr      = pc;
    assign bus.oLed        = led;
    assign bus.oOutData    = out_data;
    assign bus.oOutValid   = out_valid;
    assign bus.oHalt       = halt;
    assign bus.oStackFault = stack_fault;
endmodule
`default_nettype wire

// File: tb/tb_mini_alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_mini_alu_seq
// Purpose : Self-checking bench: instruction-level reference model feeds a
//           scoreboard of expected output bytes; a monitor checks each
//           handshake. Directed programs cover timing and fault cases.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mini_alu_seq;
    import mini_alu_defs::*;

    localparam logic [27:0] HALT_I = {OP_HALT, 24'h0};

    logic clk = 1'b0;
    logic rst;
    logic ready = 1'b0;
    logic rand_ready;
    logic forced_ready;

    always #5 clk = ~clk;

    mini_alu_seq_if #(.PC_W(16)) bus ();
    mini_alu_seq_if #(.PC_W(8))  bus8 ();

    mini_alu_seq #(.DATA_W(16), .PC_W(16), .RF_DEPTH(256), .STACK_DEPTH(4)) dut (
        .Clock (clk), .Reset (rst), .bus (bus));
    mini_alu_seq #(.DATA_W(16), .PC_W(8), .RF_DEPTH(256), .STACK_DEPTH(4)) dut8 (
        .Clock (clk), .Reset (rst), .bus (bus8));

    logic [27:0] rom [256];

    assign bus.iInstr    = (bus.oIAddr < 16'd256) ? rom[bus.oIAddr[7:0]] : HALT_I;
    assign bus.iOutReady = ready;
    assign bus8.iInstr   = (bus8.oIAddr == 8'h00) ? {OP_JMP, 8'hFF, 16'h0000} : 28'h0;
    assign bus8.iOutReady = 1'b1;

    int errors = 0;
    int checks = 0;
    int xfers  = 0;
    longint exp_q [$];

    // Reference model state
    longint mreg [256];
    int     m_pc;
    int     m_led;
    bit     m_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] mk(input logic [3:0] op, input int d, input int a, input int b);
        return {op, 8'(d), 8'(a), 8'(b)};
    endfunction

    // Ready driver: random or forced, changed just after the rising edge
    always @(posedge clk) begin
        #1;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
        else            ready = forced_ready;
    end

    // Monitor: a byte is consumed at the next rising edge whenever valid&ready
    always @(negedge clk) begin
        if (!rst && bus.oOutValid === 1'b1 && ready === 1'b1) begin
            xfers++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got byte 0x%0h expected none", bus.oOutData);
            end else begin
                check("out_byte", {24'h0, bus.oOutData}, 32'(exp_q.pop_front()));
            end
        end
    end

    // Instruction-level model: walks the program and records OUT bytes
    task automatic run_model(output bit ok);
        int pc;
        int stk [$];
        logic [27:0] ins;
        int op, d, a, b;
        pc = 0; m_led = 0; m_fault = 0; ok = 0;
        for (int step = 0; step < 300; step++) begin
            ins = (pc < 256) ? rom[pc] : HALT_I;
            op = int'(ins[27:24]); d = int'(ins[23:16]);
            a  = int'(ins[15:8]);  b = int'(ins[7:0]);
            case (op)
                1: begin mreg[d] = (mreg[a] + mreg[b]) % 65536;         pc++; end
                2: begin mreg[d] = (mreg[a] - mreg[b] + 65536) % 65536; pc++; end
                3: begin mreg[d] = a * 256 + b;                         pc++; end
                4: pc = (mreg[a] <= mreg[b]) ? d : pc + 1;
                5: pc = d;
                6: begin m_led = int'(mreg[a] % 256);                   pc++; end
                7: begin mreg[d] = (mreg[a] * mreg[b]) % 65536;         pc++; end
                8: begin
                    if (stk.size() == 4) begin m_fault = 1; m_pc = pc; ok = 1; return; end
                    stk.push_back(pc + 1); pc = d;
                end
                9: begin
                    if (stk.size() == 0) begin m_fault = 1; m_pc = pc; ok = 1; return; end
                    pc = stk.pop_back();
                end
                10: begin exp_q.push_back(mreg[b] % 256); pc++; end
                11: begin m_pc = pc; ok = 1; return; end
                default: pc++;
            endcase
            pc = pc % 65536;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = HALT_I;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic model_prog(input string name);
        bit ok;
        exp_q.delete();
        run_model(ok);
        if (!ok) $display("model for %s did not terminate", name);
    endtask

    // Wait (bounded) for halt, then compare final state with the model
    task automatic run_to_halt(input string name);
        int cyc = 0;
        while (bus.oHalt !== 1'b1 && cyc < 8000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_halt"}, {31'h0, bus.oHalt}, 32'd1);
        repeat (2) @(negedge clk);
        check({name, "_led"},   {24'h0, bus.oLed}, 32'(m_led));
        check({name, "_fault"}, {31'h0, bus.oStackFault}, {31'h0, m_fault});
        check({name, "_pc"},    {16'h0, bus.oIAddr}, 32'(m_pc));
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic nest_prog(input bit five);
        clear_rom();
        for (int i = 1; i <= 4; i++) rom[i-1] = mk(OP_STO, i, 0, 16 * i + i);
        rom[4]  = mk(OP_CALL, 10, 0, 0); rom[5]  = mk(OP_OUT, 0, 0, 1);
        rom[10] = mk(OP_CALL, 20, 0, 0); rom[11] = mk(OP_OUT, 0, 0, 2); rom[12] = mk(OP_RET, 0, 0, 0);
        rom[20] = mk(OP_CALL, 30, 0, 0); rom[21] = mk(OP_OUT, 0, 0, 3); rom[22] = mk(OP_RET, 0, 0, 0);
        rom[30] = mk(OP_CALL, 40, 0, 0); rom[31] = mk(OP_OUT, 0, 0, 4); rom[32] = mk(OP_RET, 0, 0, 0);
        rom[40] = five ? mk(OP_CALL, 50, 0, 0) : mk(OP_RET, 0, 0, 0);
        rom[50] = mk(OP_RET, 0, 0, 0);
    endtask

    initial begin
        int bad;
        int xb;
        bit ok;
        rst = 1'b1; rand_ready = 1'b0; forced_ready = 1'b0;
        clear_rom();
        repeat (3) @(negedge clk);

        // Reset values while reset is held
        check("rst_pc",    {16'h0, bus.oIAddr}, 32'd0);
        check("rst_led",   {24'h0, bus.oLed}, 32'd0);
        check("rst_odata", {24'h0, bus.oOutData}, 32'd0);
        check("rst_valid", {31'h0, bus.oOutValid}, 32'd0);
        check("rst_halt",  {31'h0, bus.oHalt}, 32'd0);
        check("rst_fault", {31'h0, bus.oStackFault}, 32'd0);

        // PC_W=8 instance: JMP 0xFF then sequential wrap to 0
        rst = 1'b0;
        @(negedge clk); check("wrap_jmp_ff", {24'h0, bus8.oIAddr}, 32'hFF);
        @(negedge clk); check("wrap_zero",   {24'h0, bus8.oIAddr}, 32'h00);

        // Arithmetic, LED timing, 16-bit SUB result confirmed by BLE
        clear_rom();
        rom[0] = mk(OP_STO, 1, 0, 5);    rom[1] = mk(OP_STO, 2, 0, 7);
        rom[2] = mk(OP_ADD, 3, 2, 1);    rom[3] = mk(OP_LED, 0, 3, 0);
        rom[4] = mk(OP_SUB, 4, 1, 2);    rom[5] = mk(OP_OUT, 0, 0, 4);
        rom[6] = mk(OP_STO, 5, 8'hFF, 8'hFE);
        rom[7] = mk(OP_BLE, 9, 5, 4);
        model_prog("arith");
        rand_ready = 1'b1;
        do_reset();
        repeat (4) @(negedge clk);
        check("led_after_4", {24'h0, bus.oLed}, 32'h0C);
        run_to_halt("arith");

        // Multiply: PC frozen for DATA_W+1 cycles, then MUL address + 1
        clear_rom();
        rom[0] = mk(OP_STO, 1, 8'h01, 8'h2C); rom[1] = mk(OP_STO, 2, 8'h01, 8'h2C);
        rom[2] = mk(OP_MUL, 3, 1, 2);         rom[3] = mk(OP_OUT, 0, 0, 3);
        rom[4] = mk(OP_STO, 4, 8'h5F, 8'h90); rom[5] = mk(OP_BLE, 7, 3, 4);
        rom[6] = HALT_I;                      rom[7] = mk(OP_BLE, 9, 4, 3);
        model_prog("mul");
        do_reset();
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (bus.oIAddr !== 16'd2) bad++;
        end
        check("mul_pc_frozen", 32'(bad), 32'd0);
        @(negedge clk); check("mul_next_pc", {16'h0, bus.oIAddr}, 32'd3);
        run_to_halt("mul");

        // Branches
        clear_rom();
        rom[0] = mk(OP_STO, 0, 0, 3); rom[1] = mk(OP_STO, 1, 0, 3); rom[2] = mk(OP_BLE, 5, 1, 0);
        model_prog("ble_taken"); do_reset(); run_to_halt("ble_taken");
        rom[0] = mk(OP_STO, 0, 0, 2);
        model_prog("ble_not"); do_reset(); run_to_halt("ble_not");

        // Call/return nesting, overflow and underflow
        nest_prog(1'b0); model_prog("nest4"); do_reset(); run_to_halt("nest4");
        nest_prog(1'b1); model_prog("nest5"); do_reset(); run_to_halt("nest5");
        repeat (5) @(negedge clk);
        check("nest5_pc_frozen", {16'h0, bus.oIAddr}, 32'd40);
        clear_rom(); rom[0] = mk(OP_RET, 0, 0, 0);
        model_prog("ret_empty"); do_reset(); run_to_halt("ret_empty");

        // Output handshake held off for 10 cycles
        clear_rom();
        rom[0] = mk(OP_STO, 1, 0, 8'h41); rom[1] = mk(OP_OUT, 0, 0, 1);
        model_prog("out_wait");
        rand_ready = 1'b0; forced_ready = 1'b0;
        do_reset();
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.oOutValid !== 1'b1 || bus.oOutData !== 8'h41 || bus.oIAddr !== 16'd1) bad++;
        end
        check("out_wait_hold", 32'(bad), 32'd0);
        xb = xfers;
        forced_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("out_valid_drop", {31'h0, bus.oOutValid}, 32'd0);
        check("out_pc_inc", {16'h0, bus.oIAddr}, 32'd2);
        run_to_halt("out_wait");
        check("out_one_xfer", 32'(xfers - xb), 32'd1);

        // Asynchronous reset in the middle of a multiply
        clear_rom(); rom[0] = mk(OP_STO, 3, 8'h12, 8'hAB);
        model_prog("preload"); rand_ready = 1'b1; do_reset(); run_to_halt("preload");
        clear_rom();
        rom[0] = mk(OP_STO, 1, 8'h01, 8'h2C); rom[1] = mk(OP_STO, 2, 8'h01, 8'h2C);
        rom[2] = mk(OP_MUL, 3, 1, 2);
        exp_q.delete();
        do_reset();
        repeat (7) @(negedge clk);
        check("pre_abort_pc", {16'h0, bus.oIAddr}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("abort_pc",    {16'h0, bus.oIAddr}, 32'd0);
        check("abort_halt",  {31'h0, bus.oHalt}, 32'd0);
        check("abort_valid", {31'h0, bus.oOutValid}, 32'd0);

        // Asynchronous reset while an output byte is pending; R3 must be intact
        clear_rom(); rom[0] = mk(OP_OUT, 0, 0, 3);
        rand_ready = 1'b0; forced_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("pend_valid", {31'h0, bus.oOutValid}, 32'd1);
        check("r3_kept",    {24'h0, bus.oOutData}, 32'hAB);
        #2 rst = 1'b1;
        #1;
        check("pend_abort_valid", {31'h0, bus.oOutValid}, 32'd0);
        model_prog("after_abort"); rand_ready = 1'b1; do_reset(); run_to_halt("after_abort");

        // Randomized programs against the model
        for (int p = 0; p < 15; p++) begin
            do begin
                clear_rom();
                for (int i = 0; i < 8; i++)
                    rom[i] = mk(OP_STO, i, $urandom_range(0, 255), $urandom_range(0, 255));
                for (int i = 8; i < 23; i++) begin
                    logic [3:0] op;
                    op = 4'($urandom_range(0, 15));
                    if (op == OP_BLE || op == OP_JMP || op == OP_CALL)
                        rom[i] = mk(op, $urandom_range(i + 1, 23), $urandom_range(0, 7), $urandom_range(0, 7));
                    else if (op == OP_STO)
                        rom[i] = mk(op, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
                    else
                        rom[i] = mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
                end
                exp_q.delete();
                run_model(ok);
            end while (!ok);
            do_reset();
            run_to_halt("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
